// File: rtl/fetch_pkg.sv
// Shared state encoding, entry layout and constants for the instruction fetch unit.
package fetch_pkg;

    localparam int              XLEN        = 32;
    localparam logic [XLEN-1:0] INSTR_BYTES = 32'd4;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    // Without prefetch the queue degenerates to a single holding register.
    function automatic int queue_capacity(input int depth, input bit prefetch_en);
        return prefetch_en ? depth : 1;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular queue of {pc, instr} entries with push, pop and flush; exposes full/empty/count.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_push,
    input  logic [XLEN-1:0] i_push_pc,
    input  logic [XLEN-1:0] i_push_instr,
    input  logic            i_pop,
    input  logic            i_flush,
    output logic [XLEN-1:0] o_head_pc,
    output logic [XLEN-1:0] o_head_instr,
    output logic            o_full,
    output logic            o_empty,
    output logic [CW-1:0]   o_count
);

    // Two slots minimum so the pointers always have a real bit to wrap.
    localparam int SLOTS = (DEPTH < 2) ? 2 : DEPTH;
    localparam int AW    = $clog2(SLOTS);

    fetch_entry_t  r_mem [SLOTS];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    // NOTE: the storage array has no reset; pointers and count define validity and the head is masked while empty.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= '{pc: i_push_pc, instr: i_push_instr};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head_pc    = r_mem[r_rd_ptr].pc;
    assign o_head_instr = r_mem[r_rd_ptr].instr;
    assign o_empty      = (r_count == '0);
    assign o_full       = (r_count == CW'(DEPTH));
    assign o_count      = r_count;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: sequential word fetch into a queue, with redirect flush and a one-cycle drain.
// Define FETCH_PREFETCH_EN for a DEPTH-entry prefetch queue; otherwise one word is fetched at a time.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              DEPTH    = 4
) (
    input  logic            clk,
    input  logic            reset,
    output logic [XLEN-1:0] mem_addr,
    output logic            mem_rstrb,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            instr_ready
);

`ifdef FETCH_PREFETCH_EN
    localparam bit PREFETCH_EN = 1'b1;
`else
    localparam bit PREFETCH_EN = 1'b0;
`endif
    localparam int QD = queue_capacity(DEPTH, PREFETCH_EN);
    localparam int CW = $clog2(QD + 1);

    fetch_state_t    r_state;
    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_req_pc;
    logic            r_inflight;

    logic [CW-1:0]   w_count;
    logic [CW:0]     w_occupancy;
    logic            w_full;
    logic            w_empty;
    logic [XLEN-1:0] w_head_pc;
    logic [XLEN-1:0] w_head_instr;
    logic            w_strobe;
    logic            w_push;
    logic            w_pop;
    logic            w_flush;

    // The outstanding read is counted so its response always has a free slot to land in.
    assign w_occupancy = {1'b0, w_count} + {{CW{1'b0}}, r_inflight};
    assign w_strobe    = (r_state == RUN) && !w_full && (w_occupancy < (CW + 1)'(QD));
    assign w_flush     = redirect_valid && (r_state != BOOT);
    assign w_push      = r_inflight && (r_state == RUN) && !redirect_valid;
    assign w_pop       = instr_valid && instr_ready;

    assign mem_rstrb   = w_strobe;
    assign mem_addr    = r_fetch_pc;
    assign instr_valid = !w_empty;
    assign instr       = w_empty ? '0 : w_head_instr;
    assign instr_pc    = w_empty ? '0 : w_head_pc;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= BOOT;
            r_fetch_pc <= RESET_PC;
            r_req_pc   <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_strobe;
            if (w_strobe) r_req_pc <= r_fetch_pc;
            case (r_state)
                BOOT: r_state <= RUN;
                RUN, DRAIN: begin
                    if (redirect_valid) begin
                        r_state    <= DRAIN;
                        r_fetch_pc <= redirect_pc & ~32'd3;
                    end else begin
                        r_state <= RUN;
                        if (w_strobe) r_fetch_pc <= r_fetch_pc + INSTR_BYTES;
                    end
                end
                default: r_state <= BOOT;
            endcase
        end
    end

    fetch_queue #(
        .DEPTH(QD),
        .CW   (CW)
    ) u_queue (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_push),
        .i_push_pc   (r_req_pc),
        .i_push_instr(mem_rdata),
        .i_pop       (w_pop),
        .i_flush     (w_flush),
        .o_head_pc   (w_head_pc),
        .o_head_instr(w_head_instr),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (w_count)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus a randomized stream scored against a program-order model.
module tb_instr_fetch_unit;

`ifdef FETCH_PREFETCH_EN
    localparam int CAP = 4;
    localparam int GAP = 1;
`else
    localparam int CAP = 1;
    localparam int GAP = 3;
`endif
    localparam logic [31:0] HI_PC = 32'hFFFF_FFF8;

    logic        clk;
    logic        reset;
    logic [31:0] mem_addr, mem_rdata, redirect_pc, instr, instr_pc;
    logic        mem_rstrb, redirect_valid, instr_valid, instr_ready;
    logic [31:0] mem_addr1, mem_rdata1, instr1, instr_pc1;
    logic        mem_rstrb1, instr_valid1;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] model_pc, model_fetch, last_strobe_addr;
    int          outstanding, strobe_cnt, pop_cnt;
    bit          cap1 = 0;
    bit          got1 = 0;
    logic [31:0] rec1 [$];
    logic [31:0] first1_pc, first1_instr;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
        .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_rstrb(mem_rstrb), .mem_rdata(mem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .instr_valid(instr_valid),
        .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready)
    );

    instr_fetch_unit #(.RESET_PC(HI_PC), .DEPTH(4)) dut_hi (
        .clk(clk), .reset(reset), .mem_addr(mem_addr1), .mem_rstrb(mem_rstrb1), .mem_rdata(mem_rdata1),
        .redirect_valid(1'b0), .redirect_pc(32'h0), .instr_valid(instr_valid1),
        .instr(instr1), .instr_pc(instr_pc1), .instr_ready(1'b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expd);
        checks++;
        assert (obs === expd) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expd);
        end
    endtask

    // One clock: score this cycle against the model, advance, then present the memory response.
    task automatic step();
        logic        s0, s1, after_redirect;
        logic [31:0] a0, a1;
        s0 = mem_rstrb;  a0 = mem_addr;
        s1 = mem_rstrb1; a1 = mem_addr1;
        after_redirect = 1'b0;
        if (reset) begin
            model_pc    = 32'h0;
            model_fetch = 32'h0;
            outstanding = 0;
        end else begin
            if (s0) begin
                check("strobe_addr", a0, model_fetch);
                model_fetch      = model_fetch + 32'd4;
                strobe_cnt++;
                last_strobe_addr = a0;
                if (!redirect_valid) outstanding++;
                check("no_overflow", 32'(outstanding <= CAP), 32'd1);
            end
            if (instr_valid && instr_ready) begin
                check("pop_pc", instr_pc, model_pc);
                check("pop_instr", instr, {2'b00, model_pc[31:2]});
                model_pc = model_pc + 32'd4;
                outstanding--;
                pop_cnt++;
            end
            if (redirect_valid) begin
                model_pc       = redirect_pc & ~32'd3;
                model_fetch    = redirect_pc & ~32'd3;
                outstanding    = 0;
                after_redirect = 1'b1;
            end
            if (cap1 && s1 && rec1.size() < 4) rec1.push_back(a1);
            if (cap1 && !got1 && instr_valid1) begin
                got1 = 1;
                first1_pc = instr_pc1;
                first1_instr = instr1;
            end
        end
        @(posedge clk);
        #1;
        mem_rdata  = s0 ? {2'b00, a0[31:2]} : $urandom;
        mem_rdata1 = s1 ? {2'b00, a1[31:2]} : $urandom;
        if (after_redirect && !reset) begin
            check("drain_valid_low", 32'(instr_valid), 32'd0);
            check("drain_rstrb_low", 32'(mem_rstrb), 32'd0);
        end
    endtask

    // Called in the BOOT cycle just after reset release, with instr_ready high.
    task automatic boot_stream(input string tag);
        for (int k = 0; k < 13; k++) begin
            check({tag, "_rstrb"}, 32'(mem_rstrb), 32'((k >= 1) && ((k - 1) % GAP == 0)));
            check({tag, "_valid"}, 32'(instr_valid), 32'((k >= 3) && ((k - 3) % GAP == 0)));
            if (k == 1) check({tag, "_first_addr"}, mem_addr, 32'h0);
            if (k == 3) begin
                check({tag, "_first_pc"}, instr_pc, 32'h0);
                check({tag, "_first_instr"}, instr, 32'h0);
            end
            step();
        end
    endtask

    initial begin
        bit          found;
        int          n0;
        logic [31:0] exp35 [4];
        exp35 = '{HI_PC, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
        reset = 1'b1; instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        mem_rdata = 32'h0; mem_rdata1 = 32'h0;
        model_pc = 32'h0; model_fetch = 32'h0; last_strobe_addr = 32'h0;
        outstanding = 0; strobe_cnt = 0; pop_cnt = 0;
        #1;
        step();
        step();

        check("rst_rstrb", 32'(mem_rstrb), 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_addr", mem_addr, 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_instr_pc", instr_pc, 32'h0);
        check("rst_addr_hi", mem_addr1, HI_PC);

        // Streaming from reset with the consumer always ready.
        instr_ready = 1'b1; reset = 1'b0; cap1 = 1;
        boot_stream("boot");
        repeat (8) step();

        check("hi_strobe_count", 32'(rec1.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            check("hi_strobe_addr", (i < rec1.size()) ? rec1[i] : 32'hxxxx_xxxx, exp35[i]);
        check("hi_first_pc", first1_pc, HI_PC);
        check("hi_first_instr", first1_instr, 32'h3FFF_FFFE);

        // Back-pressure from reset: strobes stop once the queue is full.
        reset = 1'b1; instr_ready = 1'b0;
        step();
        reset = 1'b0;
        n0 = strobe_cnt;
        repeat (20) step();
        check("bp_strobes", 32'(strobe_cnt - n0), 32'(CAP));
        check("bp_valid", 32'(instr_valid), 32'd1);
        check("bp_head_pc", instr_pc, 32'h0);
        instr_ready = 1'b1;
        n0 = strobe_cnt;
        for (int i = 0; i < 10 && strobe_cnt == n0; i++) step();
        check("bp_resume_seen", 32'(strobe_cnt > n0), 32'd1);
        check("bp_resume_addr", last_strobe_addr, 32'(4 * CAP));

        // Redirect to an unaligned target while a read is in flight.
        repeat (6) step();
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (mem_rstrb) found = 1;
            step();
        end
        check("rd1_seek", 32'(found), 32'd1);
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0043;
        step();
        redirect_valid = 1'b0;
        check("rd1_hold_addr", mem_addr, 32'h40);
        step();
        check("rd1_strobe", 32'(mem_rstrb), 32'd1);
        check("rd1_addr", mem_addr, 32'h40);
        step();
        step();
        check("rd1_valid", 32'(instr_valid), 32'd1);
        check("rd1_pc", instr_pc, 32'h40);
        check("rd1_instr", instr, 32'h10);

        // Back-to-back redirects: only the second target is fetched.
        repeat (5) step();
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        step();
        redirect_pc = 32'h200;
        step();
        redirect_valid = 1'b0;
        check("rd2_hold_addr", mem_addr, 32'h200);
        step();
        check("rd2_strobe", 32'(mem_rstrb), 32'd1);
        check("rd2_addr", mem_addr, 32'h200);
        step();
        step();
        check("rd2_valid", 32'(instr_valid), 32'd1);
        check("rd2_pc", instr_pc, 32'h200);

        // Random consumer stalls and redirects against the program-order model.
        n0 = pop_cnt;
        for (int i = 0; i < 400; i++) begin
            instr_ready    = ($urandom % 4) != 0;
            redirect_valid = ($urandom % 25) == 0;
            redirect_pc    = $urandom;
            step();
        end
        redirect_valid = 1'b0; instr_ready = 1'b1;
        repeat (10) step();
        check("rand_progress", 32'(pop_cnt > n0), 32'd1);

        // Reset mid-stream with a partly filled queue and a read outstanding.
        reset = 1'b1; instr_ready = 1'b0;
        step();
        reset = 1'b0;
        repeat (5) step();
        check("mid_valid", 32'(instr_valid), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_rstrb", 32'(mem_rstrb), 32'd0);
        check("mid_rst_valid", 32'(instr_valid), 32'd0);
        check("mid_rst_instr", instr, 32'h0);
        check("mid_rst_pc", instr_pc, 32'h0);
        check("mid_rst_addr", mem_addr, 32'h0);
        instr_ready = 1'b1;
        step();
        reset = 1'b0;
        boot_stream("reboot");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
